cam_to_ram_fifo: RTL and testbench



---
 rtl/cam_to_ram_fifo_if.sv | 30 +++
 rtl/cam_to_ram_fifo.sv | 83 ++++++++
 tb/tb_cam_to_ram_fifo.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cam_to_ram_fifo_if.sv
// cam_to_ram_fifo_if: pixel-word push/pop bus between the camera framebuffer
// (master) and the camera-to-SDRAM FIFO (slave).
//
// Handshake: a request is taken on a rising clk edge only when its side is
// able to take it. A write (wrreq) is taken when wrfull=0, and a read
// (rdreq) is taken when rdempty=0. A request raised against a full or
// empty FIFO is dropped without any side effect. There is no stall: the
// requester samples the flags itself and must not rely on a retry.
interface cam_to_ram_fifo_if #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  wrreq;
    logic                  rdreq;
    logic [DATA_WIDTH-1:0] q;
    logic                  rdempty;
    logic                  wrfull;
    logic [ADDR_WIDTH:0]   usedw;

    modport master (
        output data, wrreq, rdreq,
        input  q, rdempty, wrfull, usedw
    );

    modport slave (
        input  data, wrreq, rdreq,
        output q, rdempty, wrfull, usedw
    );
endinterface

// File: rtl/cam_to_ram_fifo.sv
// cam_to_ram_fifo: single-clock FIFO between the camera pixel stream and the
// SDRAM write port. Depth is 2**ADDR_WIDTH words.
//
// Build option CAM_TO_RAM_FIFO_SHOWAHEAD_EN: when defined, q is a
// combinational read of the head word (show-ahead), and rdreq acknowledges
// it. When undefined, q is registered and updated by each accepted read.
module cam_to_ram_fifo #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    cam_to_ram_fifo_if.slave   bus
);

    // Count value at which the FIFO is full (2**ADDR_WIDTH).
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wp;
    logic [ADDR_WIDTH-1:0] rp;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags decode the registered count only, so no input reaches an output.
    assign bus.rdempty = (count == '0);
    assign bus.wrfull  = (count == FULL_COUNT);
    assign bus.usedw   = count;

    // A full FIFO drops the write even when a read frees a slot on the same
    // edge; an empty FIFO drops the read even when a write arrives.
    assign wr_ok = bus.wrreq & ~bus.wrfull;
    assign rd_ok = bus.rdreq & ~bus.rdempty;

    // Storage array: written on accepted writes, never reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wp] <= bus.data;
        end
    end

    // Pointers wrap by natural overflow; count tracks net occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wp <= wp + 1'b1;
            end
            if (rd_ok) begin
                rp <= rp + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef CAM_TO_RAM_FIFO_SHOWAHEAD_EN
    // Show-ahead: head word is presented without waiting for rdreq.
    assign bus.q = mem[rp];
`else
    logic [DATA_WIDTH-1:0] q_r;

    // Registered read: q picks up the head word on the accepting edge and
    // holds it until the next accepted read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r <= '0;
        end else if (rd_ok) begin
            q_r <= mem[rp];
        end
    end

    assign bus.q = q_r;
`endif

endmodule

// File: tb/tb_cam_to_ram_fifo.sv
// tb_cam_to_ram_fifo: directed bench for cam_to_ram_fifo. A reference queue
// and occupancy counter predict q, usedw and the flags on every cycle.
module tb_cam_to_ram_fifo;

  localparam int DW    = 10;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic clk;
  logic reset_n;

  cam_to_ram_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cam_to_ram_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            m_count;
  logic [DW-1:0] last_q;
  int            n_compared;
  int            n_mismatched;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_usedw"},   32'(bus.usedw),   32'(m_count));
    check({tag, "_rdempty"}, 32'(bus.rdempty), 32'(m_count == 0));
    check({tag, "_wrfull"},  32'(bus.wrfull),  32'(m_count == DEPTH));
  endtask

  // ---------------- driver ----------------
  // One clock cycle with the given requests; inputs change #1 after the edge.
  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d);
    logic          wr_acc;
    logic          rd_acc;
    logic [DW-1:0] e;
    wr_acc = wr && (m_count < DEPTH);
    rd_acc = rd && (m_count > 0);
    bus.data  = d;
    bus.wrreq = wr;
    bus.rdreq = rd;
`ifdef CAM_TO_RAM_FIFO_SHOWAHEAD_EN
    if (m_count > 0) check("q_head", 32'(bus.q), 32'(exp_q[0]));
`endif
    @(posedge clk);
    #1;
    if (rd_acc) begin
      e = exp_q.pop_front();
      last_q = e;
`ifndef CAM_TO_RAM_FIFO_SHOWAHEAD_EN
      check("q_read", 32'(bus.q), 32'(e));
`endif
    end
`ifndef CAM_TO_RAM_FIFO_SHOWAHEAD_EN
    else begin
      check("q_hold", 32'(bus.q), 32'(last_q));
    end
`endif
    if (wr_acc) exp_q.push_back(d);
    if (wr_acc && !rd_acc) m_count++;
    if (rd_acc && !wr_acc) m_count--;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    check_status("step");
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, DW'((base + i) % 1024));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, '0);
  endtask

  // Asynchronous reset applied between edges and checked before any edge.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    m_count = 0;
    last_q  = '0;
    check_status(tag);
`ifndef CAM_TO_RAM_FIFO_SHOWAHEAD_EN
    check({tag, "_q"}, 32'(bus.q), 32'h0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    m_count      = 0;
    last_q       = '0;
    reset_n      = 1'b0;
    bus.data     = '0;
    bus.wrreq    = 1'b0;
    bus.rdreq    = 1'b0;

    // Reset held with random requests: nothing may move.
    for (int i = 0; i < 5; i++) begin
      bus.wrreq = 1'($urandom_range(0, 1));
      bus.rdreq = 1'($urandom_range(0, 1));
      bus.data  = DW'($urandom_range(0, 1023));
      @(posedge clk);
      #1;
      check_status("rst_hold");
`ifndef CAM_TO_RAM_FIFO_SHOWAHEAD_EN
      check("rst_q", 32'(bus.q), 32'h0);
`endif
    end
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    reset_n   = 1'b1;

    // Single word, then read it back one cycle later.
    step(1'b1, 1'b0, 10'h155);
    step(1'b0, 1'b1, '0);

    // Underflow: q holds and count stays zero.
    step(1'b0, 1'b1, 10'h0AA);
    step(1'b0, 1'b1, 10'h0BB);

    // Fill to full, overflow write dropped, drain in order.
    fill(DEPTH, 0);
    step(1'b1, 1'b0, 10'h3FF);
    drain(DEPTH);

    // Three wrap-around cycles, data = index mod 1024.
    for (int k = 0; k < 3; k++) begin
      fill(DEPTH, 256 + k * DEPTH);
      drain(DEPTH);
    end

    // Full with both requests: read wins, count -> 255.
    fill(DEPTH, 7);
    step(1'b1, 1'b1, 10'h3FF);
    drain(DEPTH - 1);

    // Empty with both requests: write wins, q unchanged, count -> 1.
    step(1'b1, 1'b1, 10'h2A5);
    drain(1);

    // Steady state at five words with both requests for 100 cycles.
    fill(5, 600);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, DW'(700 + i));
    drain(5);

`ifdef CAM_TO_RAM_FIFO_SHOWAHEAD_EN
    // Show-ahead: the written word appears on q with no rdreq.
    step(1'b1, 1'b0, 10'h2A5);
    check("sa_q_first", 32'(bus.q), 32'h2A5);
    drain(1);
`endif

    // Mid-stream asynchronous reset at 37 words.
    fill(37, 900);
    async_reset("mid_rst");

    // First edge after release accepts a write.
    step(1'b1, 1'b0, 10'h123);
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
